// File: rtl/bcd_normalize.sv
`default_nettype none
// ============================================================================
// Module   : bcd_normalize
// Purpose  : Left-justifies an N_DIG-digit BCD word one digit per cycle until
//            the top digit is non-zero or MAX_SHIFT shifts are done. Returns
//            the top N_OUT digits and the shift count that places the display
//            decimal point.
// Options  : ROUND_EN - when defined, adds a ROUND state that rounds the
//            output window half-up on the guard digit. The default build
//            truncates, and ovf stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_normalize #(
  parameter int N_DIG     = 7,
  parameter int N_OUT     = 4,
  parameter int MAX_SHIFT = 3,
  localparam int CW       = ($clog2(MAX_SHIFT + 1) < 1) ? 1 : $clog2(MAX_SHIFT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4*N_DIG-1:0] bcd_in,
  output logic [4*N_OUT-1:0] bcd_out,
  output logic [CW-1:0]      shift_cnt,
  output logic               zero,
  output logic               ovf,
  output logic               ready,
  output logic               done_tick
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [4*N_DIG-1:0] work;
  logic [CW-1:0]      cnt;
  logic               shift_more;
  logic               load_work;
  logic               do_shift;
  logic               load_result;
  logic [4*N_OUT-1:0] window;
  logic [4*N_OUT-1:0] res_out;
  logic [CW-1:0]      res_cnt;
  logic               res_ovf;

  // Another shift is taken only while the leading digit is zero and the
  // limit has not been reached; nibbles above 9 count as non-zero digits.
  assign shift_more = (work[4*N_DIG-1 -: 4] == 4'd0) && (cnt < MAX_CNT);
  assign window     = work[4*N_DIG-1 -: 4*N_OUT];
  assign ready      = (state == IDLE);

`ifdef ROUND_EN
  logic round_up;

  // The guard digit sits directly below the output window. A full-width
  // window has no guard digit and is never rounded.
  generate
    if (N_DIG > N_OUT) begin : g_guard
      assign round_up = (work[4*(N_DIG-N_OUT)-1 -: 4] >= 4'd5);
    end else begin : g_no_guard
      assign round_up = 1'b0;
    end
  endgenerate

  // Decimal +1 over the window with a full carry ripple. The result is
  // {carry_out, digits}.
  function automatic logic [4*N_OUT:0] bcd_inc(input logic [4*N_OUT-1:0] v);
    logic [4*N_OUT-1:0] r;
    logic               c;
    logic [3:0]         d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  logic [4*N_OUT:0] inc;

  // Result selection with rounding. A carry out of the MSD gives back one
  // shift if possible, or else saturates to all nines with ovf set.
  always_comb begin
    inc     = bcd_inc(window);
    res_out = window;
    res_cnt = cnt;
    res_ovf = 1'b0;
    if (round_up) begin
      if (!inc[4*N_OUT]) begin
        res_out = inc[4*N_OUT-1:0];
      end else if (cnt != '0) begin
        res_out                = '0;
        res_out[4*N_OUT-1 -: 4] = 4'd1;
        res_cnt                = cnt - CW'(1);
      end else begin
        res_out = {N_OUT{4'd9}};
        res_ovf = 1'b1;
      end
    end
  end
`else
  // Truncating result: the top window as it stands after shifting.
  always_comb begin
    res_out = window;
    res_cnt = cnt;
    res_ovf = 1'b0;
  end
`endif

  // Next-state and datapath control decode.
  always_comb begin
    state_next  = state;
    load_work   = 1'b0;
    do_shift    = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          load_work  = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_more) begin
          do_shift = 1'b1;
        end else begin
`ifdef ROUND_EN
          state_next  = ROUND;
`else
          state_next  = DONE;
          load_result = 1'b1;
`endif
        end
      end
      ROUND: begin
        state_next  = DONE;
        load_result = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working shifter, result registers and the completion pulse. Results
  // load in one step, so the outputs never show intermediate values.
  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      shift_cnt <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= (state == DONE);
      if (load_work) begin
        work <= bcd_in;
        cnt  <= '0;
      end else if (do_shift) begin
        work <= {work[4*N_DIG-5:0], 4'd0};
        cnt  <= cnt + CW'(1);
      end
      if (load_result) begin
        bcd_out   <= res_out;
        shift_cnt <= res_cnt;
        zero      <= (work == '0);
        ovf       <= res_ovf;
      end
    end
  end

endmodule
`default_nettype wire
